// File: rtl/button_conditioner.sv
// button_conditioner
//   Multi-channel push-button front end: per-channel synchroniser, debouncer,
//   registered press/release pulses and optional auto-repeat.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           event enable; 0 masks press, release and any_press
//   btn_raw      raw asynchronous button pins, active-high
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse per press (debounced press or repeat)
//   btn_release  one-cycle pulse per debounced release
//   any_press    OR of btn_press, registered alongside it
module button_conditioner #(
  parameter int unsigned        NUM_BTN         = 4,
  parameter int unsigned        SYNC_STAGES     = 2,
  parameter int unsigned        DEBOUNCE_CYCLES = 250000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0,
  parameter int unsigned        REPEAT_DELAY    = 12500000,
  parameter int unsigned        REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam int unsigned DB_MAX  = DEBOUNCE_CYCLES - 1;
  localparam int unsigned DB_W    = (DB_MAX > 0) ? $clog2(DB_MAX + 1) : 1;
  localparam int unsigned RPT_MAX =
    ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync;

  logic [DB_W-1:0]    db_cnt      [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_nxt  [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt     [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_nxt [NUM_BTN];
  rpt_state_t         rpt_state     [NUM_BTN];
  rpt_state_t         rpt_state_nxt [NUM_BTN];

  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] rpt_fire;
  logic [NUM_BTN-1:0] press_nxt;
  logic [NUM_BTN-1:0] release_nxt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_nxt = btn_level;
    rpt_fire  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync[i] != btn_level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          level_nxt[i] = sync[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end

    // Edges are taken from the next-state level so the pulses register on
    // the same edge that updates btn_level.
    rise = level_nxt & ~btn_level;
    fall = ~level_nxt & btn_level;

    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rpt_state_nxt[i] = rpt_state[i];
      rpt_cnt_nxt[i]   = rpt_cnt[i];
      if (!REPEAT_MASK[i] || fall[i]) begin
        // Release wins over a coinciding repeat tick.
        rpt_state_nxt[i] = RPT_IDLE;
        rpt_cnt_nxt[i]   = '0;
      end else if (rise[i]) begin
        rpt_state_nxt[i] = RPT_DELAY;
        rpt_cnt_nxt[i]   = '0;
      end else begin
        unique case (rpt_state[i])
          RPT_DELAY: begin
            if (rpt_cnt[i] == DELAY_LAST) begin
              rpt_fire[i]      = 1'b1;
              rpt_cnt_nxt[i]   = '0;
              rpt_state_nxt[i] = RPT_REPEAT;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt[i] == PER_LAST) begin
              rpt_fire[i]    = 1'b1;
              rpt_cnt_nxt[i] = '0;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_W'(1);
            end
          end
          default: begin
            rpt_state_nxt[i] = RPT_IDLE;
            rpt_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end

    press_nxt   = en ? (rise | rpt_fire) : '0;
    release_nxt = en ? fall : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        db_cnt[i]    <= '0;
        rpt_cnt[i]   <= '0;
        rpt_state[i] <= RPT_IDLE;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
    end else begin
      sync_q[0] <= btn_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        db_cnt[i]    <= db_cnt_nxt[i];
        rpt_cnt[i]   <= rpt_cnt_nxt[i];
        rpt_state[i] <= rpt_state_nxt[i];
      end
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      any_press   <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Self-checking bench for button_conditioner with NUM_BTN=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, REPEAT_MASK=4'b0100, REPEAT_DELAY=8, REPEAT_PERIOD=3.
//   A reference model predicts each cycle's outputs into a queue; a monitor
//   pops and compares every cycle.
module tb_button_conditioner;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       any_press;

  logic [3:0] mask;

  int checks;
  int failures;

  button_conditioner #(
    .NUM_BTN         (4),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_MASK     (4'b0100),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] hist [$];
  logic [3:0] m_lvl;
  int         press_t [4];
  int         t;

  // Reference model: the level flips once the synchronised input (raw
  // delayed by S samples) has disagreed with it for D samples in a row;
  // repeats fire RD edges after the press edge and then every RP edges.
  always @(posedge clk) begin : model
    exp_t       e;
    logic [3:0] nl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] fire;
    bit         all_diff;
    int         el;
    t = t + 1;
    e = '0;
    if (!rst_n) begin
      for (int k = 0; k < hist.size(); k++) hist[k] = '0;
      while (hist.size() < 16) hist.push_back('0);
      hist.push_back('0);
      m_lvl = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (hist[hist.size() - S - j][i] == m_lvl[i]) all_diff = 1'b0;
        end
        nl[i] = all_diff ? ~m_lvl[i] : m_lvl[i];
      end
      rise = nl & ~m_lvl;
      fall = ~nl & m_lvl;
      fire = '0;
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) begin
          press_t[i] = t;
        end else if (mask[i] && m_lvl[i] && nl[i]) begin
          el = t - press_t[i];
          if (el >= RD && ((el - RD) % RP) == 0) fire[i] = 1'b1;
        end
      end
      e.lvl   = nl;
      e.press = en ? (rise | fire) : 4'b0000;
      e.rel   = en ? fall : 4'b0000;
      e.any   = |e.press;
      hist.push_back(btn_raw);
      m_lvl = nl;
    end
    while (hist.size() > 64) void'(hist.pop_front());
    sb.push_back(e);
  end

  // Monitor: one comparison per clock, sampled away from the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_empty t=%0d no expected entry", t);
      end else begin
        e = sb.pop_front();
        if ({btn_level, btn_press, btn_release, any_press} !== e) begin
          failures = failures + 1;
          $display("FAIL cycle t=%0d got lvl=%b press=%b rel=%b any=%b expected lvl=%b press=%b rel=%b any=%b",
                   t, btn_level, btn_press, btn_release, any_press,
                   e.lvl, e.press, e.rel, e.any);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] raw, input logic en_v, input int n);
    btn_raw = raw;
    en      = en_v;
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic reset_now(input string name);
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({btn_level, btn_press, btn_release, any_press} !== 13'd0) begin
      failures = failures + 1;
      $display("FAIL %s got lvl=%b press=%b rel=%b any=%b expected all zero",
               name, btn_level, btn_press, btn_release, any_press);
    end
    @(negedge clk);
  endtask

  initial begin : stimulus
    int rem [4];
    mask     = 4'b0100;
    checks   = 0;
    failures = 0;
    t        = 0;
    m_lvl    = '0;
    for (int i = 0; i < 4; i++) press_t[i] = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 1'b1, 4);

    // Clean press and release on channel 0.
    drive(4'b0001, 1'b1, 12);
    drive(4'b0000, 1'b1, 12);

    // Bouncing channel 1: high runs of 3, low runs of 1, then a solid hold.
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, 1'b1, 3);
      drive(4'b0000, 1'b1, 1);
    end
    drive(4'b0010, 1'b1, 12);
    drive(4'b0000, 1'b1, 12);

    // Auto-repeat on channel 2.
    drive(4'b0100, 1'b1, 30);
    drive(4'b0000, 1'b1, 14);

    // Channel 3 completes a press and release while disabled.
    drive(4'b1000, 1'b0, 12);
    drive(4'b0000, 1'b0, 12);
    drive(4'b0000, 1'b1, 8);

    // Repeat channel held while disabled, then enabled mid-hold.
    drive(4'b0100, 1'b0, 14);
    drive(4'b0100, 1'b1, 12);
    drive(4'b0000, 1'b1, 12);

    // Simultaneous press on three channels.
    drive(4'b1011, 1'b1, 12);
    drive(4'b0000, 1'b1, 12);

    // Reset mid-debounce and mid-repeat, with the button held through reset.
    drive(4'b0100, 1'b1, 3);
    reset_now("reset_mid_debounce");
    drive(4'b0100, 1'b1, 2);
    rst_n = 1'b1;
    drive(4'b0100, 1'b1, 16);
    reset_now("reset_mid_repeat");
    drive(4'b0100, 1'b1, 2);
    rst_n = 1'b1;
    drive(4'b0100, 1'b1, 20);
    drive(4'b0000, 1'b1, 12);

    // Randomised phase: independent hold lengths per channel, occasional en flips.
    for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 25);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        rem[i] = rem[i] - 1;
        if (rem[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          rem[i] = (i == 2) ? $urandom_range(1, 40) : $urandom_range(1, 12);
        end
      end
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) begin
        reset_now("reset_random");
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    drive(4'b0000, 1'b1, 12);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
